// File: rtl/morphology_3x3_pkg.sv
// Shared encodings and helpers for the 3x3 binary erosion/dilation stage.
// State, LED and mode codes plus the pad and 9-input reduction rules.
package morphology_3x3_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] LED_IDLE = 2'b00;
   localparam logic [1:0] LED_BUSY = 2'b01;
   localparam logic [1:0] LED_DONE = 2'b10;

   localparam logic MODE_ERODE  = 1'b0;
   localparam logic MODE_DILATE = 1'b1;

   // Pad is the identity of the reduction, so out-of-image neighbours never change a result.
   function automatic logic pad_value(input logic mode);
      return (mode == MODE_ERODE);
   endfunction

   function automatic logic reduce9(input logic [8:0] win, input logic mode);
      return (mode == MODE_DILATE) ? (|win) : (&win);
   endfunction

endpackage

// File: rtl/morphology_3x3_if.sv
// Control, source-memory read and result-memory write signals of the morphology stage.
// The host/memory side uses master, the morphology block uses slave.
interface morphology_3x3_if #(
   parameter int ADDR_W = 16
);
   logic              morph_ctrl;
   logic              morph_mode;
   logic              bin_data;
   logic [ADDR_W-1:0] pixel_address;
   logic [ADDR_W-1:0] morph_address;
   logic              morph_data;
   logic              morph_we;
   logic [1:0]        condition_led;

   modport master (
      output morph_ctrl, morph_mode, bin_data,
      input  pixel_address, morph_address, morph_data, morph_we, condition_led
   );

   modport slave (
      input  morph_ctrl, morph_mode, bin_data,
      output pixel_address, morph_address, morph_data, morph_we, condition_led
   );
endinterface

// File: rtl/morphology_3x3_line_buf.sv
// One-row 1-bit circular line buffer: registered read, one write per cycle.
// A read and write to the same address in one cycle returns the old value.
module morphology_3x3_line_buf
   import morphology_3x3_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_we,
   input  logic [AW-1:0] i_raddr,
   input  logic [AW-1:0] i_waddr,
   input  logic          i_wdata,
   output logic          o_rdata
);

   logic r_mem [DEPTH];
   logic r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= 1'b0;
         end
         r_rdata <= 1'b0;
      end else begin
         r_rdata <= r_mem[i_raddr];
         if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
         end
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/morphology_3x3.sv
// Raster-scans a 1-bit image, applies 3x3 erosion or dilation and writes one result per pixel.
// Pipeline: issue position -> memory/line-buffer read -> window reduction into output register.
module morphology_3x3
   import morphology_3x3_pkg::*;
#(
   parameter int IMG_W  = 256,
   parameter int IMG_H  = 256,
   parameter int ADDR_W = 16
) (
   input  logic                   morph_clk,
   input  logic                   morph_rst,
   morphology_3x3_if.slave        bus
);

   localparam int COL_W = $clog2(IMG_W + 1);
   localparam int ROW_W = $clog2(IMG_H + 1);
   localparam int LB_AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H);

   state_t            r_state;
   logic              r_ctrl_q;
   logic              r_mode;
   logic [ROW_W-1:0]  r_row;
   logic [COL_W-1:0]  r_col;
   logic              r_s1_valid;
   logic [ROW_W-1:0]  r_s1_row;
   logic [COL_W-1:0]  r_s1_col;
   logic [ADDR_W-1:0] r_pix_addr;
   logic [ADDR_W-1:0] r_out_cnt;
   logic [ADDR_W-1:0] r_morph_addr;
   logic              r_morph_data;
   logic              r_morph_we;
   logic [1:0]        r_led;
   logic              r_flush_cnt;
   logic [2:0]        r_win_c1;
   logic [2:0]        r_win_c2;

   logic              w_start;
   logic              w_pad;
   logic              w_last_pos;
   logic [ROW_W-1:0]  w_next_row;
   logic [COL_W-1:0]  w_next_col;
   logic              w_next_inside;
   logic              w_s1_col_in;
   logic [2:0]        w_new;
   logic [2:0]        w_c1;
   logic [2:0]        w_c2;
   logic              w_result;
   logic              w_emit;
   logic [1:0]        w_lb_q;
   logic [1:0]        w_lb_wdata;
   logic              w_lb_we;
   logic [LB_AW-1:0]  w_lb_raddr;
   logic [LB_AW-1:0]  w_lb_waddr;

   assign w_start    = bus.morph_ctrl & ~r_ctrl_q;
   assign w_pad      = pad_value(r_mode);
   assign w_last_pos = (r_row == ROW_LAST) && (r_col == COL_LAST);

   always_comb begin
      w_next_row = r_row;
      w_next_col = r_col + COL_W'(1);
      if (r_col == COL_LAST) begin
         w_next_col = '0;
         w_next_row = r_row + ROW_W'(1);
      end
   end

   assign w_next_inside = (w_next_row < ROW_LAST) && (w_next_col < COL_LAST);

   // New window column: index 0 = row r-2, 1 = row r-1, 2 = row r; rows/cols outside the image are pad.
   assign w_s1_col_in = (r_s1_col != COL_LAST);
   assign w_new[0] = (w_s1_col_in && (r_s1_row >= ROW_W'(2))) ? w_lb_q[1]    : w_pad;
   assign w_new[1] = (w_s1_col_in && (r_s1_row >= ROW_W'(1))) ? w_lb_q[0]    : w_pad;
   assign w_new[2] = (w_s1_col_in && (r_s1_row != ROW_LAST))  ? bus.bin_data : w_pad;
   assign w_c1 = (r_s1_col >= COL_W'(1)) ? r_win_c1 : {3{w_pad}};
   assign w_c2 = (r_s1_col >= COL_W'(2)) ? r_win_c2 : {3{w_pad}};

   assign w_result = reduce9({w_c2, w_c1, w_new}, r_mode);
   assign w_emit   = r_s1_valid && (r_s1_row != '0) && (r_s1_col != '0);

   // Buffer 0 holds row r-1, buffer 1 holds row r-2; each row shifts down one buffer as it is consumed.
   assign w_lb_we       = r_s1_valid && w_s1_col_in;
   assign w_lb_raddr    = (r_col != COL_LAST) ? r_col[LB_AW-1:0] : '0;
   assign w_lb_waddr    = r_s1_col[LB_AW-1:0];
   assign w_lb_wdata[0] = w_new[2];
   assign w_lb_wdata[1] = w_lb_q[0];

   for (genvar gi = 0; gi < 2; gi++) begin : g_lb
      morphology_3x3_line_buf #(
         .DEPTH (IMG_W),
         .AW    (LB_AW)
      ) u_lb (
         .i_clk   (morph_clk),
         .i_rst   (morph_rst),
         .i_we    (w_lb_we),
         .i_raddr (w_lb_raddr),
         .i_waddr (w_lb_waddr),
         .i_wdata (w_lb_wdata[gi]),
         .o_rdata (w_lb_q[gi])
      );
   end

   always_ff @(posedge morph_clk) begin
      if (morph_rst) begin
         r_state      <= ST_IDLE;
         r_ctrl_q     <= 1'b0;
         r_mode       <= MODE_ERODE;
         r_row        <= '0;
         r_col        <= '0;
         r_s1_valid   <= 1'b0;
         r_s1_row     <= '0;
         r_s1_col     <= '0;
         r_pix_addr   <= '0;
         r_out_cnt    <= '0;
         r_morph_addr <= '0;
         r_morph_data <= 1'b0;
         r_morph_we   <= 1'b0;
         r_led        <= LED_IDLE;
         r_flush_cnt  <= 1'b0;
         r_win_c1     <= '0;
         r_win_c2     <= '0;
      end else begin
         r_ctrl_q   <= bus.morph_ctrl;
         r_s1_valid <= 1'b0;
         r_morph_we <= 1'b0;

         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_start) begin
                  r_state    <= ST_SCAN;
                  r_mode     <= bus.morph_mode;
                  r_row      <= '0;
                  r_col      <= '0;
                  r_pix_addr <= '0;
                  r_out_cnt  <= '0;
                  r_led      <= LED_BUSY;
               end
            end
            ST_SCAN: begin
               r_s1_valid <= 1'b1;
               r_s1_row   <= r_row;
               r_s1_col   <= r_col;
               if (w_last_pos) begin
                  r_state     <= ST_FLUSH;
                  r_flush_cnt <= 1'b0;
               end else begin
                  r_row <= w_next_row;
                  r_col <= w_next_col;
                  // Pad positions hold the address, so the next in-image pixel is always one more.
                  if (w_next_inside) begin
                     r_pix_addr <= r_pix_addr + ADDR_W'(1);
                  end
               end
            end
            ST_FLUSH: begin
               r_flush_cnt <= 1'b1;
               if (r_flush_cnt) begin
                  r_state <= ST_DONE;
                  r_led   <= LED_DONE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         if (r_s1_valid) begin
            r_win_c2 <= r_win_c1;
            r_win_c1 <= w_new;
         end

         if (w_emit) begin
            r_morph_we   <= 1'b1;
            r_morph_data <= w_result;
            r_morph_addr <= r_out_cnt;
            r_out_cnt    <= r_out_cnt + ADDR_W'(1);
         end
      end
   end

   assign bus.pixel_address = r_pix_addr;
   assign bus.morph_address = r_morph_addr;
   assign bus.morph_data    = r_morph_data;
   assign bus.morph_we      = r_morph_we;
   assign bus.condition_led = r_led;

endmodule

// File: tb/tb_morphology_3x3.sv
// Bench for morphology_3x3 on an 8x8 image: a neighbourhood-based reference model checks every
// write, with literal expectations for the directed corner/dilation cases.
module tb_morphology_3x3;
   localparam int W  = 8;
   localparam int H  = 8;
   localparam int AW = 6;
   localparam int N  = W * H;
   localparam int BUSY_CYCLES = (W + 1) * (H + 1) + 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   morphology_3x3_if #(.ADDR_W(AW)) bus_if ();

   morphology_3x3 #(
      .IMG_W  (W),
      .IMG_H  (H),
      .ADDR_W (AW)
   ) dut (
      .morph_clk (clk),
      .morph_rst (rst),
      .bus       (bus_if)
   );

   bit img [N];
   bit out_mem [N];
   int errors = 0;
   int checks = 0;
   int wr_idx = 0;
   int busy_cycles = 0;
   bit cur_mode = 1'b0;

   // Source memory with one cycle of read latency.
   always @(posedge clk) bus_if.bin_data <= img[bus_if.pixel_address];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Result pixel straight from the definition: reduce the 3x3 neighbourhood, outside = identity.
   function automatic bit model_px(input int r, input int c, input bit mode);
      bit acc = (mode == 1'b0);
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            int rr = r + dr;
            int cc = c + dc;
            bit v;
            if (rr < 0 || rr >= H || cc < 0 || cc >= W) v = (mode == 1'b0);
            else v = img[rr * W + cc];
            acc = mode ? (acc | v) : (acc & v);
         end
      end
      return acc;
   endfunction

   function automatic int count_ones();
      int n = 0;
      foreach (out_mem[i]) n += int'(out_mem[i]);
      return n;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (bus_if.condition_led == 2'b01) busy_cycles++;
         if (bus_if.morph_we) begin
            bit exp_d;
            exp_d = (wr_idx < N) ? model_px(wr_idx / W, wr_idx % W, cur_mode) : 1'b0;
            $display("write #%0d addr=%0d data=%0d busy_cycle=%0d", wr_idx,
                     bus_if.morph_address, bus_if.morph_data, busy_cycles);
            check("we_only_when_busy", int'(bus_if.condition_led), 1);
            check("wr_addr", int'(bus_if.morph_address), wr_idx);
            check("wr_data", int'(bus_if.morph_data), int'(exp_d));
            if (wr_idx == 0) check("first_we_latency", busy_cycles, W + 1 + 1 + 3);
            out_mem[bus_if.morph_address] = bus_if.morph_data;
            wr_idx++;
         end
      end
   end

   task automatic randomize_img(input int density);
      foreach (img[i]) img[i] = ($urandom_range(99) < density);
   endtask

   task automatic start_pass(input bit mode, input bit hold);
      cur_mode = mode;
      wr_idx = 0;
      busy_cycles = 0;
      foreach (out_mem[i]) out_mem[i] = 1'b0;
      bus_if.morph_mode = mode;
      bus_if.morph_ctrl = 1'b0;
      @(negedge clk);
      bus_if.morph_ctrl = 1'b1;
      @(negedge clk);
      if (!hold) bus_if.morph_ctrl = 1'b0;
      bus_if.morph_mode = ~mode;  // must be ignored once latched
   endtask

   task automatic finish_pass(input string tag);
      int n = 0;
      while (bus_if.condition_led != 2'b10 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done_led"}, int'(bus_if.condition_led), 2);
      check({tag, "_writes"}, wr_idx, N);
      check({tag, "_busy_cycles"}, busy_cycles, BUSY_CYCLES);
   endtask

   task automatic wait_busy(input int target, input string tag);
      int n = 0;
      while (busy_cycles < target && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_busy_reached"}, int'(busy_cycles >= target), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_if.morph_ctrl = 1'b0;
      bus_if.morph_mode = 1'b0;
      foreach (img[i]) img[i] = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_pixel_address", int'(bus_if.pixel_address), 0);
      check("rst_morph_address", int'(bus_if.morph_address), 0);
      check("rst_morph_data", int'(bus_if.morph_data), 0);
      check("rst_morph_we", int'(bus_if.morph_we), 0);
      check("rst_led", int'(bus_if.condition_led), 0);

      // 1: all ones, erosion
      foreach (img[i]) img[i] = 1'b1;
      start_pass(1'b0, 1'b0);
      finish_pass("t1");
      check("t1_ones", count_ones(), 64);

      // 2: single pixel, dilation
      foreach (img[i]) img[i] = 1'b0;
      img[4 * W + 4] = 1'b1;
      check("t2_model_pin", int'(model_px(3, 3, 1'b1)), 1);
      start_pass(1'b1, 1'b0);
      finish_pass("t2");
      check("t2_ones", count_ones(), 9);
      check("t2_px27", int'(out_mem[27]), 1);
      check("t2_px36", int'(out_mem[36]), 1);
      check("t2_px45", int'(out_mem[45]), 1);
      check("t2_px26", int'(out_mem[26]), 0);
      check("t2_px30", int'(out_mem[30]), 0);
      check("t2_px53", int'(out_mem[53]), 0);

      // 3: one zero at the corner, erosion
      foreach (img[i]) img[i] = 1'b1;
      img[0] = 1'b0;
      start_pass(1'b0, 1'b0);
      finish_pass("t3");
      check("t3_ones", count_ones(), 60);
      check("t3_px0", int'(out_mem[0]), 0);
      check("t3_px1", int'(out_mem[1]), 0);
      check("t3_px8", int'(out_mem[8]), 0);
      check("t3_px9", int'(out_mem[9]), 0);
      check("t3_px2", int'(out_mem[2]), 1);
      check("t3_px18", int'(out_mem[18]), 1);

      // 4: held start plus a fresh edge mid-scan must not retrigger
      randomize_img(80);
      start_pass(1'b0, 1'b1);
      wait_busy(20, "t4");
      bus_if.morph_ctrl = 1'b0;
      repeat (2) @(negedge clk);
      bus_if.morph_ctrl = 1'b1;
      finish_pass("t4");
      repeat (30) @(negedge clk);
      check("t4_writes_after", wr_idx, N);
      check("t4_led_after", int'(bus_if.condition_led), 2);
      bus_if.morph_ctrl = 1'b0;

      // 5: reset mid-scan, then a clean pass
      randomize_img(30);
      start_pass(1'b1, 1'b0);
      wait_busy(30, "t5");
      rst = 1'b1;
      @(negedge clk);
      check("t5_rst_we", int'(bus_if.morph_we), 0);
      check("t5_rst_led", int'(bus_if.condition_led), 0);
      check("t5_rst_maddr", int'(bus_if.morph_address), 0);
      rst = 1'b0;
      wr_idx = 0;
      busy_cycles = 0;
      repeat (20) @(negedge clk);
      check("t5_idle_writes", wr_idx, 0);
      check("t5_idle_led", int'(bus_if.condition_led), 0);
      start_pass(1'b1, 1'b0);
      finish_pass("t5_fresh");

      // 6: back-to-back from DONE with the mode flipped, then random passes
      randomize_img(70);
      start_pass(1'b0, 1'b0);
      finish_pass("t6_flip");
      for (int k = 0; k < 4; k++) begin
         bit m;
         m = 1'($urandom_range(1));
         randomize_img(m ? 15 : 85);
         start_pass(m, 1'b0);
         finish_pass("t6_rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
